uart_rx_fsm: RTL

Receive-side frame controller for the UART RX path. Tracks an oversampled serial line through start, data, optional parity and stop bits. Issues the sampling and shift strobes to the data sampler and the deserializer, and reports frame validity plus parity and stop errors. It sits between the synchronized `rx_in` line and sampler on one side and the 8-bit deserializer and RX output register on the other.

---
 rtl/uart_rx_pkg.sv | 22 ++
 rtl/uart_rx_fsm_edge_bit_counter.sv | 57 +++++
 rtl/uart_rx_fsm.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX frame controller.
// UART_RX_PARITY_EN adds the PARITY state to rx_state_t.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned PRESCALE_8  = 32'd8;
  localparam int unsigned PRESCALE_16 = 32'd16;
  localparam int unsigned PRESCALE_32 = 32'd32;

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Oversample edge counter and bit counter for the UART RX frame controller.
// The edge count wraps at prescale-1 and advances the bit count; clear beats enable.
module edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic [BIT_W-1:0]      bit_cnt_o
);

  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  wrap_s;

  assign wrap_s = (edge_q == (prescale_i - PRESCALE_W'(1)));

  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clr_i) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (en_i) begin
      if (wrap_s) begin
        edge_d = '0;
        bit_d  = bit_q + BIT_W'(1);
      end else begin
        edge_d = edge_q + PRESCALE_W'(1);
        bit_d  = bit_q;
      end
    end else begin
      edge_d = edge_q;
      bit_d  = bit_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// Receive-side UART frame controller: start/data/parity/stop tracking and error flags.
// Define UART_RX_PARITY_EN to compile in the PARITY state and parity checking.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  sampled_bit,
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  deser_en,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  // bit_cnt runs 0 (start) .. DATA_W (last data bit) .. DATA_W+2 (stop with parity)
  localparam int               BIT_W         = $clog2(DATA_W + 3);
  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_W);

  rx_state_t             state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  stp_err_q, stp_err_d;
  logic                  data_valid_q, data_valid_d;
  logic [PRESCALE_W-1:0] edge_cnt_s;
  logic [BIT_W-1:0]      bit_cnt_s;
  logic                  chk_s, bit_end_s, cnt_en_s, cnt_clr_s;

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic acc_q, acc_d, par_err_q, par_err_d;
`else
  logic unused_par_s;
  assign unused_par_s = par_en ^ par_typ;
`endif

  assign chk_s     = (edge_cnt_s == ((prescale_q >> 1) + PRESCALE_W'(2)));
  assign bit_end_s = (edge_cnt_s == (prescale_q - PRESCALE_W'(1)));
  assign cnt_en_s  = (state_q != IDLE);
  assign cnt_clr_s = (state_d == IDLE);

  edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_W      (BIT_W)
  ) u_edge_bit_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (cnt_en_s),
    .clr_i      (cnt_clr_s),
    .prescale_i (prescale_q),
    .edge_cnt_o (edge_cnt_s),
    .bit_cnt_o  (bit_cnt_s)
  );

  always_comb begin
    state_d      = state_q;
    prescale_d   = prescale_q;
    stp_err_d    = stp_err_q;
    data_valid_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    acc_d        = acc_q;
    par_err_d    = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d    = START;
          prescale_d = prescale;
          stp_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_en_d   = par_en;
          par_typ_d  = par_typ;
          acc_d      = 1'b0;
          par_err_d  = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (chk_s && sampled_bit) begin
          state_d = IDLE;
        end else if (bit_end_s) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
`ifdef UART_RX_PARITY_EN
        if (chk_s) begin
          acc_d = acc_q ^ sampled_bit;
        end else begin
          acc_d = acc_q;
        end
`endif
        if (bit_end_s && (bit_cnt_s == LAST_DATA_BIT)) begin
`ifdef UART_RX_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (chk_s) begin
          par_err_d = (sampled_bit != (acc_q ^ (par_typ_q == PAR_ODD)));
        end else begin
          par_err_d = par_err_q;
        end
        if (bit_end_s) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        // Leave at CHK to catch a back-to-back start; the bit-end exit only
        // matters for illegal prescale values whose CHK is never reached.
        if (chk_s) begin
          state_d      = IDLE;
          stp_err_d    = !sampled_bit;
`ifdef UART_RX_PARITY_EN
          data_valid_d = sampled_bit && !par_err_q;
`else
          data_valid_d = sampled_bit;
`endif
        end else if (bit_end_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prescale_q   <= '0;
      stp_err_q    <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescale_q   <= prescale_d;
      stp_err_q    <= stp_err_d;
      data_valid_q <= data_valid_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      acc_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      acc_q     <= acc_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign busy        = (state_q != IDLE);
  assign dat_samp_en = (state_q != IDLE);
  assign deser_en    = (state_q == DATA) && chk_s;
  assign edge_cnt    = edge_cnt_s;
  assign data_valid  = data_valid_q;
  assign stp_err     = stp_err_q;

endmodule
